// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types for the instruction fetch slice.
// Imported by the prefetch FIFO and the fetch unit.
package fetch_pkg;

  localparam int PC_W    = 25;
  localparam int INSTR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_BUSY,
    WAIT_DONE
  } fetch_state_t;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_entry_t;

  function automatic logic [PC_W-1:0] align_pc(
    input logic [PC_W-1:0] pc
  );
    return {pc[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: prefetch queue of {instr, pc} entries.
// Head is presented straight from storage registers.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [CW-1:0] count,
  output logic         head_valid,
  output fetch_entry_t head_data
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] cnt;
  logic          do_pop;
  logic          do_push;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != CW'(DEPTH)) || do_pop);

  // Storage, pointers and occupancy; flush empties the queue outright.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  assign count      = cnt;
  assign head_valid = (cnt != '0);
  assign head_data  = mem[rd_ptr];

endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: PC owner issuing single-word reads to the SDRAM
// instruction port and queueing results for decode.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 25'h0000000,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               mem_enable,
  input  logic               mem_valid,
  output logic [PC_W-1:0]    mem_addr,
  input  logic [INSTR_W-1:0] mem_result,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t    state;
  fetch_state_t    state_n;
  logic [PC_W-1:0] fetch_pc;
  logic            stale;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     occupied;
  logic            busy;
  logic            slot_free;
  logic            issue;
  logic            done;
  logic            push;
  logic            pop;
  fetch_entry_t    push_data;
  fetch_entry_t    head;

  // An outstanding request reserves a FIFO slot for its result.
  assign busy      = (state != IDLE);
  assign occupied  = {1'b0, fifo_count} + {{CW{1'b0}}, busy};
  assign slot_free = (occupied < (CW+1)'(FIFO_DEPTH));

  assign push      = done && !stale && !redirect_valid;
  assign pop       = out_valid && out_ready;
  assign push_data = '{instr: mem_result, pc: mem_addr};

  // Request handshake sequencing.
  always_comb begin
    state_n = state;
    issue   = 1'b0;
    done    = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_valid && slot_free && !redirect_valid) begin
          issue   = 1'b1;
          state_n = WAIT_BUSY;
        end
      end
      WAIT_BUSY: begin
        if (!mem_valid) begin
          state_n = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (mem_valid) begin
          done    = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Request outputs, PC and stale tracking for redirected requests.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_enable <= 1'b0;
      mem_addr   <= RESET_PC;
      fetch_pc   <= RESET_PC;
      stale      <= 1'b0;
    end else begin
      mem_enable <= issue;
      if (issue) begin
        mem_addr <= fetch_pc;
        fetch_pc <= fetch_pc + 25'd4;
      end
      if (redirect_valid) begin
        fetch_pc <= align_pc(redirect_pc);
      end
      if (done) begin
        stale <= 1'b0;
      end else if (redirect_valid && busy) begin
        stale <= 1'b1;
      end
    end
  end

  fetch_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .count     (fifo_count),
    .head_valid(out_valid),
    .head_data (head)
  );

  assign out_instr = head.instr;
  assign out_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed bench with an 8-cycle controller model
// and an in-order PC stream model for two fetch units.
module tb_instr_fetch;

  localparam logic [24:0] RPC_A = 25'h0000000;
  localparam logic [24:0] RPC_B = 25'h1FFFFF8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        redirect_valid = 1'b0;
  logic [24:0] redirect_pc = '0;
  logic        mem_enable;
  logic        mem_valid = 1'b1;
  logic [24:0] mem_addr;
  logic [31:0] mem_result = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_instr;
  logic [24:0] out_pc;

  logic        b_redirect_valid = 1'b0;
  logic [24:0] b_redirect_pc = '0;
  logic        b_mem_enable;
  logic        b_mem_valid = 1'b1;
  logic [24:0] b_mem_addr;
  logic [31:0] b_mem_result = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b1;
  logic [31:0] b_out_instr;
  logic [24:0] b_out_pc;

  instr_fetch #(.RESET_PC(RPC_A), .FIFO_DEPTH(2)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .mem_enable(mem_enable), .mem_valid(mem_valid),
    .mem_addr(mem_addr), .mem_result(mem_result),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_instr(out_instr), .out_pc(out_pc)
  );

  instr_fetch #(.RESET_PC(RPC_B), .FIFO_DEPTH(2)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
    .mem_enable(b_mem_enable), .mem_valid(b_mem_valid),
    .mem_addr(b_mem_addr), .mem_result(b_mem_result),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_instr(b_out_instr), .out_pc(b_out_pc)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Controller model: result word is {7'h0, addr}, valid low 7 cycles.
  int busy_a = 0;
  always @(posedge clk) begin
    if (mem_enable === 1'b1) begin
      busy_a     <= 7;
      mem_valid  <= 1'b0;
      mem_result <= {7'h0, mem_addr};
    end else if (busy_a > 0) begin
      busy_a <= busy_a - 1;
      if (busy_a == 1) mem_valid <= 1'b1;
    end
  end

  int busy_b = 0;
  always @(posedge clk) begin
    if (b_mem_enable === 1'b1) begin
      busy_b       <= 7;
      b_mem_valid  <= 1'b0;
      b_mem_result <= {7'h0, b_mem_addr};
    end else if (busy_b > 0) begin
      busy_b <= busy_b - 1;
      if (busy_b == 1) b_mem_valid <= 1'b1;
    end
  end

  // Stream model A: requests and outputs walk PCs in steps of 4,
  // restarting at the aligned redirect target.
  logic [24:0] ma_out = RPC_A;
  logic [24:0] ma_req = RPC_A;
  bit          ma_prev = 1'b0;
  int          n_pops = 0;
  int          en_cnt = 0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      ma_out  = RPC_A;
      ma_req  = RPC_A;
      ma_prev = 1'b0;
    end else begin
      chk("a_en_consec", 32'(ma_prev & mem_enable), 32'h0);
      if (mem_enable) begin
        chk("a_req_addr", 32'(mem_addr), 32'(ma_req));
        ma_req = ma_req + 25'd4;
        en_cnt++;
      end
      if (out_valid && out_ready) begin
        chk("a_out_pc", 32'(out_pc), 32'(ma_out));
        chk("a_out_instr", out_instr, {7'h0, ma_out});
        ma_out = ma_out + 25'd4;
        n_pops++;
      end
      if (redirect_valid) begin
        ma_out = {redirect_pc[24:2], 2'b00};
        ma_req = ma_out;
      end
      ma_prev = mem_enable;
    end
  end

  // Stream model B (wrapping reset PC, no redirects).
  logic [24:0] mb_out = RPC_B;
  logic [24:0] mb_req = RPC_B;
  bit          mb_prev = 1'b0;
  logic [24:0] b_first [3];
  int          b_seen = 0;
  always @(negedge clk) begin
    #2;
    if (!rst_n) begin
      mb_out  = RPC_B;
      mb_req  = RPC_B;
      mb_prev = 1'b0;
    end else begin
      chk("b_en_consec", 32'(mb_prev & b_mem_enable), 32'h0);
      if (b_mem_enable) begin
        chk("b_req_addr", 32'(b_mem_addr), 32'(mb_req));
        mb_req = mb_req + 25'd4;
      end
      if (b_out_valid && b_out_ready) begin
        chk("b_out_pc", 32'(b_out_pc), 32'(mb_out));
        chk("b_out_instr", b_out_instr, {7'h0, mb_out});
        if (b_seen < 3) b_first[b_seen] = b_out_pc;
        b_seen++;
        mb_out = mb_out + 25'd4;
      end
      mb_prev = b_mem_enable;
    end
  end

  task automatic wait_en(input string name, input int maxc);
    int i = 0;
    do begin
      @(negedge clk);
      #3;
      i++;
    end while (!mem_enable && i < maxc);
    chk(name, 32'(mem_enable), 32'h1);
  endtask

  task automatic wait_ov(input string name, input int maxc);
    int i = 0;
    do begin
      @(negedge clk);
      #3;
      i++;
    end while (!out_valid && i < maxc);
    chk(name, 32'(out_valid), 32'h1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int i;
    // Reset values.
    repeat (3) @(negedge clk);
    #3;
    chk("rst_en", 32'(mem_enable), 32'h0);
    chk("rst_addr", 32'(mem_addr), 32'h0);
    chk("rst_valid", 32'(out_valid), 32'h0);
    chk("rst_instr", out_instr, 32'h0);
    chk("rst_pc", 32'(out_pc), 32'h0);
    chk("rst_b_addr", 32'(b_mem_addr), 32'h1FFFFF8);
    repeat (8) @(negedge clk);
    rst_n = 1'b1;

    // Straight-line fetch.
    @(negedge clk);
    #3;
    chk("first_en", 32'(mem_enable), 32'h1);
    chk("first_addr", 32'(mem_addr), 32'h0);
    repeat (9) @(negedge clk);
    #3;
    chk("first_valid", 32'(out_valid), 32'h1);
    chk("first_pc", 32'(out_pc), 32'h0);
    i = 0;
    while (n_pops < 4 && i < 100) begin
      @(negedge clk);
      #3;
      i++;
    end
    chk("four_pops", 32'(n_pops >= 4), 32'h1);

    // Backpressure from a clean start.
    @(negedge clk);
    rst_n = 1'b0;
    out_ready = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    en_cnt = 0;
    repeat (40) @(negedge clk);
    #3;
    chk("bp_enables", 32'(en_cnt), 32'd2);
    chk("bp_valid", 32'(out_valid), 32'h1);
    chk("bp_head", 32'(out_pc), 32'h0);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #3;
    chk("bp_en_early", 32'(mem_enable), 32'h0);
    @(negedge clk);
    #3;
    chk("bp_resume_en", 32'(mem_enable), 32'h1);
    chk("bp_resume_addr", 32'(mem_addr), 32'h8);

    // Reset while WAIT_DONE holds one queued entry.
    @(negedge clk);
    rst_n = 1'b0;
    out_ready = 1'b0;
    repeat (10) @(negedge clk);
    rst_n = 1'b1;
    repeat (14) @(negedge clk);
    #3;
    chk("mid_pre_valid", 32'(out_valid), 32'h1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #3;
    chk("mid_valid", 32'(out_valid), 32'h0);
    chk("mid_en", 32'(mem_enable), 32'h0);
    chk("mid_addr", 32'(mem_addr), 32'h0);
    repeat (9) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    #3;
    chk("mid_first_en", 32'(mem_enable), 32'h1);
    chk("mid_first_addr", 32'(mem_addr), 32'h0);

    // Redirect during WAIT_BUSY of the 0x8 request.
    i = 0;
    do begin
      @(negedge clk);
      #3;
      i++;
    end while (!(mem_enable && mem_addr == 25'h8) && i < 60);
    chk("find_req8", 32'(mem_enable && mem_addr == 25'h8), 32'h1);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 25'h40;
    @(negedge clk);
    redirect_valid = 1'b0;
    wait_en("redir_en", 40);
    chk("redir_addr", 32'(mem_addr), 32'h40);
    wait_ov("redir_ov", 40);
    chk("redir_out_pc", 32'(out_pc), 32'h40);

    // Misaligned redirect while decode stalls on a full head.
    @(negedge clk);
    out_ready = 1'b0;
    wait_ov("mis_pre_ov", 40);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc = 25'h43;
    @(negedge clk);
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    #3;
    chk("flush_valid", 32'(out_valid), 32'h0);
    wait_en("mis_en", 40);
    chk("mis_addr", 32'(mem_addr), 32'h40);
    wait_ov("mis_ov", 40);
    chk("mis_out_pc", 32'(out_pc), 32'h40);
    chk("mis_out_instr", out_instr, 32'h40);

    // Wrap-around sequence from the second unit.
    repeat (20) @(negedge clk);
    chk("wrap_seen", 32'(b_seen >= 3), 32'h1);
    chk("wrap0", 32'(b_first[0]), 32'h1FFFFF8);
    chk("wrap1", 32'(b_first[1]), 32'h1FFFFFC);
    chk("wrap2", 32'(b_first[2]), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit sitting directly upstream of the SDRAM controller's instruction port. It owns the program counter and issues single-word fetch requests over the controller's enable/valid handshake. Returned words go into a small prefetch FIFO, with the PC of each word, for the decode stage. Branch/jump redirects flush the FIFO and discard any in-flight result.

## Interface
Parameters:
- RESET_PC, 25'h0000000, PC loaded on reset; bits [1:0] must be 0.
- FIFO_DEPTH, 2, prefetch entries; power of two, 2..8.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- redirect_valid  in  1  one-cycle pulse: flush and restart fetch at redirect_pc.
- redirect_pc  in  25  new PC; bits [1:0] ignored (treated as 0).
- mem_enable  out  1  request pulse to controller instr_enable.
- mem_valid  in  1  controller instr_valid (high = idle/result ready).
- mem_addr  out  25  byte address to controller instr_addr.
- mem_result  in  32  controller instr_result.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  decode accepts head.
- out_instr  out  32  head instruction word.
- out_pc  out  25  head instruction PC.

## Operation
- Reset values: mem_enable=0, mem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, fetch_pc=RESET_PC, FIFO empty, stale=0, state=IDLE.
- Slot rule: a request may issue only if FIFO count + (state!=IDLE) < FIFO_DEPTH.
- FSM:
  - IDLE: if mem_valid && slot free && !redirect_valid, register mem_enable=1, mem_addr=fetch_pc, fetch_pc+=4; go WAIT_BUSY.
  - WAIT_BUSY: mem_enable=0; when mem_valid==0, go WAIT_DONE.
  - WAIT_DONE: when mem_valid==1, push {mem_result, mem_addr} unless stale; clear stale; go IDLE.
- mem_enable is high for exactly one cycle per request, never two consecutive cycles.
- Redirect:
  - flush FIFO the same edge.
  - fetch_pc = {redirect_pc[24:2],2'b00}.
  - if state!=IDLE, set stale.
  - a push coinciding with the redirect is dropped.
- FIFO: push and pop in the same cycle is allowed, including when full (net count unchanged). Pop happens when out_valid && out_ready. A pop in the same cycle as a redirect is still accepted by decode.
- PC arithmetic is 25-bit modulo: 0x1FFFFFC + 4 wraps to 0x0000000.
- Reset mid-request forces IDLE. The bench holds rst_n long enough (≥9 cycles) for the controller to drain.

## Timing
- Issue: mem_enable rises on the edge after IDLE sees mem_valid && slot free.
- Request lifetime with the controller's 8-cycle delay:
  - 1 cycle for enable.
  - Controller drops mem_valid one cycle after sampling enable and keeps it low for 7 cycles.
  - Push happens the cycle mem_valid returns high.
- out_valid rises the cycle after the push (registered FIFO outputs).
- Back-to-back requests: the next enable follows the push cycle by one cycle. This gives a throughput of 1 word per 10 cycles with the 8-cycle controller.
- Redirect-to-first-enable: 1 cycle if IDLE. Otherwise 1 cycle after the stale request completes.
- out_valid drops on the edge following a redirect.

## Structure
- Package fetch_pkg:
  - typedef enum {IDLE, WAIT_BUSY, WAIT_DONE} fetch_state_t.
  - typedef struct {logic [31:0] instr; logic [24:0] pc;} fetch_entry_t.
  - localparam PC_W=25.
  - localparam INSTR_W=32.
- Sub-module fetch_fifo:
  - parameterised DEPTH, payload fetch_entry_t.
  - push/pop/flush inputs, count output, registered head.
  - shared synchronous reset.
- Top module instr_fetch: FSM, PC register, stale flag, slot rule.

## Test plan
- Straight-line: memory model returns word = {7'h0, addr} after 8 cycles; out_ready=1 → outputs pc 0x0,0x4,0x8,0xC in order, each instr matching, mem_enable never high two consecutive cycles.
- Backpressure: out_ready=0 → exactly FIFO_DEPTH pushes then no further mem_enable. Raising out_ready → next enable within 2 cycles after the first pop.
- Redirect mid-request: redirect to 0x40 during WAIT_BUSY → stale word (pc 0x8) never appears. First output pc 0x40; next enable carries addr 0x40.
- Misaligned redirect: redirect_pc=0x43 → mem_addr 0x40, out_pc 0x40.
- Wrap-around: RESET_PC=0x1FFFFF8 → out_pc sequence 0x1FFFFF8, 0x1FFFFFC, 0x0000000.
- Reset mid-operation: rst_n low during WAIT_DONE with FIFO holding 1 entry → next cycle out_valid=0, mem_enable=0, mem_addr=RESET_PC. After release, first fetch is from RESET_PC.
